mips_muldiv_ctrl: RTL and testbench

- Iterative multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair for the MIPS core.
- Replaces the single-cycle multiply/divide path: MULT/MULTU/DIV/DIVU run over 33 cycles; MTHI/MTLO complete in one cycle.
- Accepts one operation at a time from the decode/execute stage through a valid/ready handshake.
- Drives a stall to the pipeline while a result is pending; HI/LO are read combinationally by the MFHI/MFLO path.

---
 rtl/mips_muldiv_ctrl_if.sv | 28 ++
 rtl/mips_muldiv_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mips_muldiv_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_ctrl_if.sv
// Request/result bundle between the decode/execute stage and the multiply/divide sequencer.
// master = pipeline side, slave = mips_muldiv_ctrl.
interface mips_muldiv_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_ready;
  logic             flush;
  logic             hilo_rd;
  logic             stall;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op_code, op_a, op_b, flush, hilo_rd,
    input  op_ready, stall, busy, done, hi, lo
  );

  modport slave (
    input  op_valid, op_code, op_a, op_b, flush, hilo_rd,
    output op_ready, stall, busy, done, hi, lo
  );
endinterface

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO (33-cycle ops, single-cycle MTHI/MTLO).
// Define MULDIV_SIGNED_EN for signed MULT/DIV; otherwise they behave as MULTU/DIVU.
module mips_muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_muldiv_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     hi_q, lo_q;
  logic                 done_q;
  logic                 busy;
  logic                 accept;
  logic                 is_mul, is_div;
  logic                 last_iter;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   mul_step, div_step;
  logic [WIDTH-1:0]     fix_hi, fix_lo;

  assign busy      = (state != IDLE);
  assign accept    = bus.op_valid && !busy && !bus.flush;
  assign is_mul    = (bus.op_code == OP_MULTU) || (bus.op_code == OP_MULT);
  assign is_div    = (bus.op_code == OP_DIVU)  || (bus.op_code == OP_DIV);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
  logic a_neg, b_neg;
  logic neg_p, neg_q, neg_r;

  assign a_neg = bus.op_code[0] && bus.op_a[WIDTH-1];
  assign b_neg = bus.op_code[0] && bus.op_b[WIDTH-1];
  assign mag_a = a_neg ? -bus.op_a : bus.op_a;
  assign mag_b = b_neg ? -bus.op_b : bus.op_b;

  // Sign corrections are decided at accept time; the quotient of a divide by zero stays all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_p <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (state == IDLE && accept) begin
      neg_p <= is_mul && (a_neg ^ b_neg);
      neg_q <= is_div && (a_neg ^ b_neg) && (bus.op_b != '0);
      neg_r <= is_div && a_neg;
    end
  end
`else
  assign mag_a = bus.op_a;
  assign mag_b = bus.op_b;
`endif

  // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_reg};
    mul_step  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_reg};
    div_ge    = (div_shift >= {1'b0, b_reg});
    div_step  = div_ge ? {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                       : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_comb begin
    fix_hi = acc[2*WIDTH-1:WIDTH];
    fix_lo = acc[WIDTH-1:0];
`ifdef MULDIV_SIGNED_EN
    if (neg_p) {fix_hi, fix_lo} = -acc;
    if (neg_q) fix_lo = -acc[WIDTH-1:0];
    if (neg_r) fix_hi = -acc[2*WIDTH-1:WIDTH];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = DIV;
      end
      MUL, DIV: begin
        if (bus.flush)      state_next = IDLE;
        else if (last_iter) state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      acc    <= '0;
      b_reg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (bus.op_code == OP_MTHI) hi_q <= bus.op_a;
            if (bus.op_code == OP_MTLO) lo_q <= bus.op_a;
            if (is_mul) begin
              acc   <= {{WIDTH{1'b0}}, mag_b};
              b_reg <= mag_a;
            end
            if (is_div) begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              b_reg <= mag_b;
            end
          end
        end
        MUL: begin
          acc <= mul_step;
          cnt <= cnt + CNT_W'(1);
        end
        DIV: begin
          acc <= div_step;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          if (!bus.flush) begin
            hi_q   <= fix_hi;
            lo_q   <= fix_lo;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.op_ready = !busy;
  assign bus.busy     = busy;
  assign bus.stall    = busy && bus.hilo_rd;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Self-checking bench for mips_muldiv_ctrl: vector table, randomized ops against a reference model,
// and hand-written contention/flush/reset sequences.
module tb_mips_muldiv_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  mips_muldiv_ctrl_if #(.WIDTH(32)) bus ();

  mips_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] m_hi, m_lo;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain wide arithmetic from the architectural definition of each op.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] cur_hi, input logic [31:0] cur_lo);
    longint unsigned up;
    longint          sp;
    int              sa, sb;
    logic [2:0]      eff;
    eff = op;
    if (!SIGNED_EN && (op == 3'd1 || op == 3'd3)) eff = op - 3'd1;
    case (eff)
      3'd0: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        return up;
      end
      3'd1: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
      end
      3'd4:    return {a, cur_lo};
      3'd5:    return {cur_hi, a};
      default: return {cur_hi, cur_lo};
    endcase
  endfunction

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    int busy_cycles;
    guard = 0;
    while (!bus.op_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    bus.op_valid = 1'b0;
    if (op <= 3'd3) begin
      busy_cycles = 0;
      while (bus.busy && busy_cycles < 100) begin
        busy_cycles++;
        @(negedge clk);
      end
      checkOutput("latency", 64'(busy_cycles), 64'd33);
      checkOutput("done_pulse", 64'(bus.done), 64'd1);
      @(negedge clk);
      checkOutput("done_clear", 64'(bus.done), 64'd0);
    end else begin
      checkOutput("no_busy", 64'(bus.busy), 64'd0);
      checkOutput("no_done", 64'(bus.done), 64'd0);
    end
  endtask

  initial begin
    int cnt;
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [63:0] exp;

    pass_cnt     = 0;
    total_cnt    = 0;
    rst_n        = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 3'd6;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.flush    = 1'b0;
    bus.hilo_rd  = 1'b0;

    vecs[0]  = '{"multu_max",  3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"divu_100_7", 3'd2, 32'd100, 32'd7, 32'd2, 32'd14};
    vecs[2]  = '{"divu_by0",   3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
    vecs[3]  = '{"mthi",       3'd4, 32'h0000_CAFE, 32'd0, 32'h0000_CAFE, 32'hFFFF_FFFF};
    vecs[4]  = '{"mtlo",       3'd5, 32'h0000_BEEF, 32'd0, 32'h0000_CAFE, 32'h0000_BEEF};
    vecs[5]  = '{"nop",        3'd6, 32'h1111_1111, 32'h2222_2222, 32'h0000_CAFE, 32'h0000_BEEF};
    vecs[6]  = '{"multu_zero", 3'd0, 32'd0, 32'h1234_5678, 32'd0, 32'd0};
    vecs[11] = '{"div_neg_by0", 3'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    if (SIGNED_EN) begin
      vecs[7]  = '{"mult_m3_4",   3'd1, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4};
      vecs[8]  = '{"div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[9]  = '{"div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
      vecs[10] = '{"div_7_m2",    3'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD};
    end else begin
      vecs[7]  = '{"mult_m3_4",   3'd1, 32'hFFFF_FFFD, 32'd4, 32'h0000_0003, 32'hFFFF_FFF4};
      vecs[8]  = '{"div_m7_2",    3'd3, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC};
      vecs[9]  = '{"div_ovf",     3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
      vecs[10] = '{"div_7_m2",    3'd3, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd0};
    end

    repeat (2) @(negedge clk);
    checkOutput("rst_hi", 64'(bus.hi), 64'd0);
    checkOutput("rst_lo", 64'(bus.lo), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_ready", 64'(bus.op_ready), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
      checkOutput({vecs[i].name, "_hi"}, 64'(bus.hi), 64'(vecs[i].exp_hi));
      checkOutput({vecs[i].name, "_lo"}, 64'(bus.lo), 64'(vecs[i].exp_lo));
    end
    m_hi = vecs[11].exp_hi;
    m_lo = vecs[11].exp_lo;

    for (int i = 0; i < 30; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin
        r_a = 32'h8000_0000;
        r_b = 32'hFFFF_FFFF;
      end
      exp = model(r_op, r_a, r_b, m_hi, m_lo);
      applyStimulus(r_op, r_a, r_b);
      checkOutput("rand_hilo", {bus.hi, bus.lo}, exp);
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end

    // MTHI held off behind a running MULTU; MFHI/MFLO stalls meanwhile.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd0;
    bus.op_a     = 32'd3;
    bus.op_b     = 32'd5;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd4;
    bus.op_a     = 32'h1234;
    bus.hilo_rd  = 1'b1;
    #1;
    checkOutput("cont_ready", 64'(bus.op_ready), 64'd0);
    checkOutput("cont_stall", 64'(bus.stall), 64'd1);
    checkOutput("cont_hi_hold", 64'(bus.hi), 64'(m_hi));
    cnt = 0;
    while (bus.busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("cont_busy_fall", 64'(bus.busy), 64'd0);
    checkOutput("cont_stall_off", 64'(bus.stall), 64'd0);
    checkOutput("cont_mul_hi", 64'(bus.hi), 64'd0);
    checkOutput("cont_mul_lo", 64'(bus.lo), 64'd15);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.hilo_rd  = 1'b0;
    checkOutput("cont_mthi_hi", 64'(bus.hi), 64'h1234);
    checkOutput("cont_mthi_lo", 64'(bus.lo), 64'd15);
    checkOutput("cont_mthi_busy", 64'(bus.busy), 64'd0);

    // Flush a DIVU at iteration 10.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd2;
    bus.op_a     = 32'd1000;
    bus.op_b     = 32'd3;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy", 64'(bus.busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    checkOutput("flush_no_done", 64'(cnt), 64'd0);
    checkOutput("flush_hi", 64'(bus.hi), 64'h1234);
    checkOutput("flush_lo", 64'(bus.lo), 64'd15);

    // Flush on the accepting edge cancels both MTLO and MULTU.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd5;
    bus.op_a     = 32'hDEAD;
    bus.flush    = 1'b1;
    @(negedge clk);
    checkOutput("flush_acc_mtlo", 64'(bus.lo), 64'd15);
    bus.op_code = 3'd0;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    checkOutput("flush_acc_mul", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of a MULTU.
    bus.op_valid = 1'b1;
    bus.op_code  = 3'd0;
    bus.op_a     = 32'd7;
    bus.op_b     = 32'd9;
    @(negedge clk);
    bus.op_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_hi", 64'(bus.hi), 64'd0);
    checkOutput("arst_lo", 64'(bus.lo), 64'd0);
    checkOutput("arst_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) cnt++;
    end
    checkOutput("arst_quiet", 64'(cnt), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
